// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between write-back (always wins) and a
// small FIFO of long-latency results that drains on idle write-back cycles.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [ADDR_WIDTH-1:0]    wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     lu_valid,
  input  logic [ADDR_WIDTH-1:0]    lu_addr,
  input  logic [DATA_WIDTH-1:0]    lu_data,
  output logic                     lu_ready,
  output logic                     rf_write,
  output logic [ADDR_WIDTH-1:0]    rf_addr3,
  output logic [DATA_WIDTH-1:0]    rf_data3,
  output logic [2**ADDR_WIDTH-1:0] pending,
  output logic                     drain_req
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0]      fifo_live;
  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic pop;
  logic push;

  // Handshake: a result transfers at a posedge where lu_valid && lu_ready; lu_ready
  // never depends on lu_valid, and an offered result may change only after transfer.
  assign pop       = !reset && !wb_valid && (count != '0);
  assign lu_ready  = !reset && ((count < FULL) || pop);
  assign push      = lu_valid && lu_ready;
  assign drain_req = !reset && (count == FULL) && wb_valid;

  always_comb begin
    rf_write = 1'b0;
    rf_addr3 = '0;
    rf_data3 = '0;
    if (!reset) begin
      if (wb_valid) begin
        rf_write = 1'b1;
        rf_addr3 = wb_addr;
        rf_data3 = wb_data;
      end else if (pop) begin
        rf_write = fifo_live[head];
        rf_addr3 = fifo_addr[head];
        rf_data3 = fifo_data[head];
      end
    end
  end

  // Popped slots have live cleared, so only occupied entries can contribute here.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live[i]) pending[fifo_addr[i]] = 1'b1;
    end
    if (reset) pending = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fifo_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid && (fifo_addr[i] == wb_addr)) fifo_live[i] <= 1'b0;
      end
      if (pop) begin
        fifo_live[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      // Push comes last: when full, the popped slot is the one being refilled.
      if (push) begin
        fifo_live[tail] <= !(wb_valid && (lu_addr == wb_addr));
        fifo_addr[tail] <= lu_addr;
        fifo_data[tail] <= lu_data;
        tail            <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: hand-computed port values per cycle plus a
// shadow register file fed from the write port to catch lost or duplicate writes.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic        lu_valid;
  logic [1:0]  lu_addr;
  logic [15:0] lu_data;
  logic        lu_ready;
  logic        rf_write;
  logic [1:0]  rf_addr3;
  logic [15:0] rf_data3;
  logic [3:0]  pending;
  logic        drain_req;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int wr_base;
  logic [15:0] rf_m [4];

  rf_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .rf_write(rf_write), .rf_addr3(rf_addr3), .rf_data3(rf_data3),
    .pending(pending), .drain_req(drain_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write) begin
      rf_m[rf_addr3] <= rf_data3;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic wv, input logic [1:0] wa, input logic [15:0] wd,
                       input logic lv, input logic [1:0] la, input logic [15:0] ld);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic port(input string tag, input logic we, input logic [1:0] a, input logic [15:0] d);
    check({tag, ".rf_write"}, 32'(rf_write), 32'(we));
    if (we) begin
      check({tag, ".rf_addr3"}, 32'(rf_addr3), 32'(a));
      check({tag, ".rf_data3"}, 32'(rf_data3), 32'(d));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf_m[i] = 16'h0;
    reset = 1'b1;
    drive(1'b1, 2'd1, 16'hDEAD, 1'b1, 2'd1, 16'hDEAD);
    tick();
    // Outputs forced while reset is high, even with requests present
    check("rst.rf_write", 32'(rf_write), 32'd0);
    check("rst.lu_ready", 32'(lu_ready), 32'd0);
    check("rst.pending", 32'(pending), 32'd0);
    check("rst.drain_req", 32'(drain_req), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    check("post_rst.rf_write", 32'(rf_write), 32'd0);
    check("post_rst.lu_ready", 32'(lu_ready), 32'd1);
    check("post_rst.pending", 32'(pending), 32'd0);
    check("post_rst.drain_req", 32'(drain_req), 32'd0);
    check("post_rst.wr_cnt", 32'(wr_cnt), 32'd0);

    // Single long-latency result, one-cycle latency
    drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 16'hBEEF);
    check("lu1.lu_ready", 32'(lu_ready), 32'd1);
    port("lu1.c0", 1'b0, 2'd0, 16'h0);
    tick();
    idle();
    check("lu1.pending_c1", 32'(pending), 32'b0100);
    port("lu1.c1", 1'b1, 2'd2, 16'hBEEF);
    tick();
    check("lu1.pending_c2", 32'(pending), 32'b0000);
    port("lu1.c2", 1'b0, 2'd0, 16'h0);
    check("lu1.rf2", 32'(rf_m[2]), 32'hBEEF);

    // Continuous write-back fills the FIFO
    drive(1'b1, 2'd1, 16'h0011, 1'b1, 2'd3, 16'h3333);
    check("fill.c0.lu_ready", 32'(lu_ready), 32'd1);
    check("fill.c0.drain_req", 32'(drain_req), 32'd0);
    port("fill.c0", 1'b1, 2'd1, 16'h0011);
    tick();
    drive(1'b1, 2'd1, 16'h0011, 1'b1, 2'd0, 16'h0A0A);
    check("fill.c1.lu_ready", 32'(lu_ready), 32'd1);
    check("fill.c1.pending", 32'(pending), 32'b1000);
    check("fill.c1.drain_req", 32'(drain_req), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'd1, 16'h0011, 1'b1, 2'd2, 16'h5555);
      check("full.lu_ready", 32'(lu_ready), 32'd0);
      check("full.drain_req", 32'(drain_req), 32'd1);
      check("full.pending", 32'(pending), 32'b1001);
      port("full", 1'b1, 2'd1, 16'h0011);
      tick();
    end
    idle();
    check("drain.c0.lu_ready", 32'(lu_ready), 32'd1);
    check("drain.c0.drain_req", 32'(drain_req), 32'd0);
    port("drain.c0", 1'b1, 2'd3, 16'h3333);
    tick();
    check("drain.c1.pending", 32'(pending), 32'b0001);
    port("drain.c1", 1'b1, 2'd0, 16'h0A0A);
    tick();
    check("drain.c2.pending", 32'(pending), 32'b0000);
    port("drain.c2", 1'b0, 2'd0, 16'h0);
    check("drain.rf1", 32'(rf_m[1]), 32'h0011);
    check("drain.rf3", 32'(rf_m[3]), 32'h3333);
    check("drain.rf0", 32'(rf_m[0]), 32'h0A0A);

    // WAW kill of a buffered entry
    wr_base = wr_cnt;
    drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 16'h1234);
    tick();
    drive(1'b1, 2'd2, 16'h5678, 1'b0, 2'd0, 16'h0);
    check("waw.c1.pending", 32'(pending), 32'b0100);
    port("waw.c1", 1'b1, 2'd2, 16'h5678);
    tick();
    idle();
    check("waw.c2.pending", 32'(pending), 32'b0000);
    check("waw.c2.lu_ready", 32'(lu_ready), 32'd1);
    port("waw.c2", 1'b0, 2'd0, 16'h0);
    tick();
    port("waw.c3", 1'b0, 2'd0, 16'h0);
    check("waw.rf2", 32'(rf_m[2]), 32'h5678);
    check("waw.writes", 32'(wr_cnt - wr_base), 32'd1);

    // Same-cycle write-back and result to the same register
    wr_base = wr_cnt;
    drive(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd1, 16'hBBBB);
    check("same.lu_ready", 32'(lu_ready), 32'd1);
    port("same.c0", 1'b1, 2'd1, 16'hAAAA);
    tick();
    idle();
    check("same.c1.pending", 32'(pending), 32'b0000);
    port("same.c1", 1'b0, 2'd0, 16'h0);
    tick();
    port("same.c2", 1'b0, 2'd0, 16'h0);
    check("same.rf1", 32'(rf_m[1]), 32'hAAAA);
    check("same.writes", 32'(wr_cnt - wr_base), 32'd1);

    // Reset discards buffered live entries
    wr_base = wr_cnt;
    drive(1'b1, 2'd0, 16'h0001, 1'b1, 2'd2, 16'h2222);
    tick();
    drive(1'b1, 2'd0, 16'h0002, 1'b1, 2'd3, 16'h7777);
    tick();
    idle();
    check("rst2.pending_before", 32'(pending), 32'b1100);
    reset = 1'b1;
    #2;
    check("rst2.rf_write", 32'(rf_write), 32'd0);
    check("rst2.pending", 32'(pending), 32'd0);
    check("rst2.lu_ready", 32'(lu_ready), 32'd0);
    tick();
    reset = 1'b0;
    #2;
    check("rst2.after.lu_ready", 32'(lu_ready), 32'd1);
    check("rst2.after.pending", 32'(pending), 32'd0);
    port("rst2.after.c0", 1'b0, 2'd0, 16'h0);
    tick();
    port("rst2.after.c1", 1'b0, 2'd0, 16'h0);
    check("rst2.writes", 32'(wr_cnt - wr_base), 32'd2);
    check("rst2.rf2", 32'(rf_m[2]), 32'h5678);
    check("rst2.rf3", 32'(rf_m[3]), 32'h3333);
    check("rst2.rf0", 32'(rf_m[0]), 32'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the in-order pipeline write-back stage and the long-latency unit (multi-cycle ALU ops, cache-miss load returns). Write-back always wins the port. Long-latency results are held in a small FIFO and drained on idle write-back cycles. The block kills buffered results that a younger write-back overwrites (WAW), and exports a pending-register mask plus a drain request to the hazard unit.

## Interface
- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 2, register address width (4 registers)
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- wb_valid  in  1  write-back stage writes this cycle (cannot be stalled)
- wb_addr  in  ADDR_WIDTH  write-back destination
- wb_data  in  DATA_WIDTH  write-back data
- lu_valid  in  1  long-latency result offered
- lu_addr  in  ADDR_WIDTH  long-latency destination
- lu_data  in  DATA_WIDTH  long-latency data
- lu_ready  out  1  result accepted when lu_valid && lu_ready at posedge
- rf_write  out  1  to RF write enable
- rf_addr3  out  ADDR_WIDTH  to RF write address
- rf_data3  out  DATA_WIDTH  to RF write data
- pending  out  2**ADDR_WIDTH  bit r set while a live (unkilled) FIFO entry targets r
- drain_req  out  1  asks the hazard unit for a write-back bubble

## Operation
- FIFO entries hold {live, addr, data}. Head and tail pointers wrap modulo DEPTH. An occupancy counter runs 0..DEPTH.
- Port select is combinational from the current inputs and FIFO head:
  - wb_valid: rf_write=1 and port = wb_addr/wb_data. The FIFO is not popped.
  - else FIFO non-empty: the head is popped. rf_write = head.live, port = head addr/data. A dead head is popped with rf_write=0 and consumes the cycle.
  - else rf_write=0. rf_addr3/rf_data3 are don't-care; drive 0.
- lu_ready = (count < DEPTH) || (pop this cycle). Same-cycle push and pop is allowed when full.
- Accepted results always enter the FIFO. There is no same-cycle bypass.
- WAW kill: when wb_valid, every stored entry with addr == wb_addr has live cleared at the posedge. An entry accepted in the same cycle with lu_addr == wb_addr is stored dead.
- pending is the OR of the one-hot addr over all live entries. It is combinational from registered FIFO state.
- drain_req = (count == DEPTH) && wb_valid. It is combinational; the hazard unit responds by deasserting wb_valid next cycle.
- Reset, while reset is high:
  - count=0, pointers=0, all live=0.
  - Outputs are forced to rf_write=0, lu_ready=0, pending=0, drain_req=0.
  - Reset mid-operation discards all buffered entries without writing them.

## Timing
- Write-back path: zero added latency. The RF captures at the posedge of the cycle in which wb_valid is high.
- Long-latency path: minimum one cycle from acceptance to rf_write. With an empty FIFO and no write-back, data accepted at edge N is written at edge N+1.
- Pops occur strictly in acceptance order; an entry of age k waits for k-1 drain cycles ahead of it.
- Full FIFO with continuous wb_valid: lu_ready stays 0 and drain_req stays 1 until write-back idles.
- No request is lost and none is written twice.
- The RF's internal forward covers the write cycle itself. pending covers every cycle before that.

## Test plan
- Reset for 2 cycles, then idle: rf_write=0, lu_ready=1, pending=4'b0000, drain_req=0 on the first post-reset cycle.
- Offer lu r2=16'hBEEF with wb idle: accepted at edge 1; rf_write=1, rf_addr3=2, rf_data3=16'hBEEF at edge 2; pending=4'b0100 for exactly one cycle.
- Write-back r1=16'h0011 every cycle while lu offers r3=16'h3333 then r0=16'h0A0A:
  - FIFO fills and lu_ready=0; drain_req=1 once count==2.
  - After wb_valid drops, r3 is written, then r0, in that order.
- Buffer r2=16'h1234, then write-back r2=16'h5678 before the drain:
  - RF r2 ends at 16'h5678.
  - The dead head pops with rf_write=0; pending bit 2 clears at the write-back edge.
- Same-cycle wb r1=16'hAAAA and lu r1=16'hBBBB: the lu result is accepted dead, r1 stays 16'hAAAA, and no second write occurs.
- Two live entries buffered, then assert reset for 1 cycle: no rf_write afterwards, count=0, pending=0, lu_ready=1 after reset deasserts.
